i2c_target_regfile: RTL and testbench
=====================================

// Module: i2c_target_regfile
// PURPOSE
//   Synchronous, oversampled I2C target (slave) fronting a parametrised byte-wide register file.
//   All logic runs on one system clock; SCL/SDA are synchronised, glitch-filtered and edge-detected.
//   Supports pointer-addressed multi-byte writes/reads with auto-increment and repeated START.
//   Registers are shared with on-chip logic through a host port. Sits between the pad ring and control/status logic.
// PARAMETERS
//   REG_AW      4   register index width; register file depth = 2**REG_AW bytes
//   FILTER_LEN  3   clk cycles a synchronised SCL/SDA level must be stable before it is accepted (>=1)
// PORTS
//   clk         in   1        system clock; all state changes on its rising edge
//   reset       in   1        synchronous, active-high reset
//   scl_in      in   1        raw SCL pin level (asynchronous)
//   sda_in      in   1        raw SDA pin level (asynchronous)
//   sda_oe      out  1        1 = pull SDA low; 0 = release (pad: SDA = sda_oe ? 1'b0 : 1'bz)
//   address     in   7        7-bit target address; sampled at the 8th address bit
//   host_we     in   1        host write enable, 1 cycle
//   host_addr   in   REG_AW   host register index (read and write)
//   host_wdata  in   8        host write data
//   host_rdata  out  8        reg[host_addr], combinational
//   wr_strobe   out  1        1-cycle pulse: I2C master wrote a register
//   wr_idx      out  REG_AW   index written, valid with wr_strobe
//   busy        out  1        1 from address match until STOP / repeated START
// BEHAVIOUR
//   Reset: sda_oe=0, busy=0, wr_strobe=0, wr_idx=0, pointer=0, all registers=8'h00, state=IDLE, filters=1.
//   Input path: 2-FF sync, then filter; filtered level changes only after FILTER_LEN equal samples.
//     Input-to-event latency = 2+FILTER_LEN clks. SCL high/low phases must be >= FILTER_LEN+4 clks.
//   Events (filtered): START = SDA 1->0 while SCL=1; STOP = SDA 0->1 while SCL=1.
//     SCL rise = sample; SCL fall = drive.
//   START/STOP override every state in the same cycle.
//     START -> ADDR, bit count=0, sda_oe=0. STOP -> IDLE, sda_oe=0, busy=0.
//   States:
//     IDLE    - wait for START.
//     ADDR    - shift 8 bits MSB-first on SCL rise.
//               Match (bits[7:1]==address) -> ADDR_ACK, busy=1, store R/W bit. Mismatch -> IGNORE.
//     ADDR_ACK - on next SCL fall set sda_oe=1; on the following fall release.
//               R/W=0 -> RX_PTR. R/W=1 -> load tx byte = reg[pointer] and drive MSB -> TX.
//     RX_PTR  - receive 8 bits; pointer <= byte[REG_AW-1:0] (upper bits ignored); ACK as above -> RX_DATA.
//     RX_DATA - receive 8 bits; at the 8th rise write reg[pointer], pulse wr_strobe, wr_idx=pointer.
//               pointer++ (wraps 2**REG_AW-1 -> 0); ACK; stay RX_DATA.
//     TX      - shift tx byte on each SCL fall (sda_oe = ~bit); after the 8th bit release SDA -> TX_ACK.
//     TX_ACK  - sample SDA on SCL rise; pointer++ (wrap) regardless of ACK.
//               ACK(0): on fall load reg[pointer] and drive MSB -> TX.
//               NACK(1): -> IGNORE, SDA released.
//     IGNORE  - SDA released; wait for START or STOP.
//   Each SDA change occurs 1 clk after the SCL-fall event; never while SCL is high except via START/STOP.
//   tx byte is snapshotted at load; host writes during a byte do not change bits already in flight.
//   Simultaneous host_we and I2C write to the same index: I2C write wins; wr_strobe still pulses.
//   Pointer persists across transactions and repeated STARTs (write-pointer then Sr+read is supported).
//   reset mid-transfer: SDA released next cycle; the bus is ignored until the next START.
// TESTING
//   1. Reset, address=7'h42. Write 0x84,0x05,0xAA,0xBB,STOP -> ACK on all 4 bytes;
//      reg[5]=AA, reg[6]=BB; two wr_strobe pulses (idx 5, 6); busy 1->0 on STOP.
//   2. Host writes reg[3]=0x5C. Master: 0x84,0x03,Sr,0x85, read 2 bytes (ACK, NACK)
//      -> returns 0x5C then reg[4]; pointer ends at 5; SDA released after NACK.
//   3. Address 0x90 while address=7'h42 -> no ACK (sda_oe stays 0), busy=0, no reg change until the next START.
//   4. REG_AW=4: pointer 0x0F, write 3 bytes -> regs 0xF,0x0,0x1 written (wrap); pointer byte 0xF3 -> pointer=3.
//   5. 1-clk glitches (width < FILTER_LEN) on SCL during the data phase -> no extra bit shifted, data intact.
//   6. Assert reset mid-TX with sda_oe=1 -> sda_oe=0 next clk; all outputs at reset values;
//      next full write transaction ACKs normally.

Source files
------------

// File: rtl/i2c_target_regfile_if.sv
// Host-side port of the I2C target register file.
//   host_we/host_addr/host_wdata : on-chip host write port (1-cycle write enable)
//   host_rdata                   : combinational read of reg[host_addr]
//   wr_strobe/wr_idx             : 1-cycle notification of a register written from the I2C bus
// Modports: master = on-chip control logic, slave = the register file.
interface i2c_target_regfile_if #(
  parameter int unsigned REG_AW = 4
);
  logic              host_we;
  logic [REG_AW-1:0] host_addr;
  logic [7:0]        host_wdata;
  logic [7:0]        host_rdata;
  logic              wr_strobe;
  logic [REG_AW-1:0] wr_idx;

  modport master (
    output host_we, host_addr, host_wdata,
    input  host_rdata, wr_strobe, wr_idx
  );

  modport slave (
    input  host_we, host_addr, host_wdata,
    output host_rdata, wr_strobe, wr_idx
  );
endinterface

// File: rtl/i2c_target_regfile.sv
// Oversampled I2C target fronting a byte-wide register file of 2**REG_AW entries.
// SCL/SDA are synchronised (2 FF), glitch-filtered (FILTER_LEN stable samples) and
// edge-detected on clk. Pointer-addressed writes/reads with auto-increment and
// repeated START; the pointer persists across transactions.
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   scl_in, sda_in    raw pin levels (asynchronous)
//   sda_oe            1 = pull SDA low
//   address           7-bit target address
//   busy              high from address match until STOP / repeated START
//   host              host register port (see i2c_target_regfile_if)
module i2c_target_regfile #(
  parameter int unsigned REG_AW     = 4,
  parameter int unsigned FILTER_LEN = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 scl_in,
  input  logic                 sda_in,
  output logic                 sda_oe,
  input  logic [6:0]           address,
  output logic                 busy,
  i2c_target_regfile_if.slave  host
);

  localparam int unsigned DEPTH = 2**REG_AW;
  localparam int unsigned CW    = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(FILTER_LEN - 1);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_ADDR     = 3'd1;
  localparam logic [2:0] ST_ADDR_ACK = 3'd2;
  localparam logic [2:0] ST_RX_PTR   = 3'd3;
  localparam logic [2:0] ST_RX_DATA  = 3'd4;
  localparam logic [2:0] ST_TX       = 3'd5;
  localparam logic [2:0] ST_TX_ACK   = 3'd6;
  localparam logic [2:0] ST_IGNORE   = 3'd7;

  // ---------------- input conditioning: index 1 = SCL, index 0 = SDA
  logic [1:0]    sync1, sync2, filt, filt_d;
  logic [CW-1:0] cnt [2];

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1  <= '1;
      sync2  <= '1;
      filt   <= '1;
      filt_d <= '1;
      for (int unsigned i = 0; i < 2; i++) cnt[i] <= '0;
    end else begin
      sync1  <= {scl_in, sda_in};
      sync2  <= sync1;
      filt_d <= filt;
      for (int unsigned i = 0; i < 2; i++) begin
        // A new level is accepted only after FILTER_LEN consecutive differing samples.
        if (sync2[i] == filt[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          filt[i] <= sync2[i];
          cnt[i]  <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  logic scl_f, sda_f, scl_d, sda_d;
  logic scl_rise, scl_fall, start_ev, stop_ev;

  always_comb begin
    scl_f    = filt[1];
    sda_f    = filt[0];
    scl_d    = filt_d[1];
    sda_d    = filt_d[0];
    scl_rise = scl_f & ~scl_d;
    scl_fall = ~scl_f & scl_d;
    start_ev = scl_f & scl_d & sda_d & ~sda_f;
    stop_ev  = scl_f & scl_d & ~sda_d & sda_f;
  end

  // ---------------- protocol state
  logic [2:0]        state;
  logic [3:0]        bitcnt;
  logic [6:0]        shreg;
  logic [7:0]        tx_sh;
  logic              rw;
  logic              addr_ack_on;
  logic [1:0]        ack_ph;   // RX byte ACK: 0 idle, 1 assert on next fall, 2 release on next fall
  logic              nack;
  logic [REG_AW-1:0] ptr;
  logic [7:0]        regs [DEPTH];
  logic [7:0]        rx_byte;
  logic [7:0]        tx_cur;

  always_comb begin
    rx_byte = {shreg, sda_f};
    tx_cur  = regs[ptr];
  end

  assign host.host_rdata = regs[host.host_addr];

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      bitcnt      <= '0;
      shreg       <= '0;
      tx_sh       <= '0;
      rw          <= 1'b0;
      addr_ack_on <= 1'b0;
      ack_ph      <= '0;
      nack        <= 1'b0;
      ptr         <= '0;
      sda_oe      <= 1'b0;
      busy        <= 1'b0;
      host.wr_strobe <= 1'b0;
      host.wr_idx    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      host.wr_strobe <= 1'b0;
      // Host write first; a same-cycle bus write below to the same index overrides it.
      if (host.host_we) regs[host.host_addr] <= host.host_wdata;

      if (start_ev) begin
        state       <= ST_ADDR;
        bitcnt      <= '0;
        sda_oe      <= 1'b0;
        busy        <= 1'b0;
        addr_ack_on <= 1'b0;
        ack_ph      <= '0;
      end else if (stop_ev) begin
        state       <= ST_IDLE;
        sda_oe      <= 1'b0;
        busy        <= 1'b0;
        addr_ack_on <= 1'b0;
        ack_ph      <= '0;
      end else begin
        case (state)
          ST_ADDR: begin
            if (scl_rise) begin
              shreg <= rx_byte[6:0];
              if (bitcnt == 4'd7) begin
                bitcnt <= '0;
                if (rx_byte[7:1] == address) begin
                  state <= ST_ADDR_ACK;
                  busy  <= 1'b1;
                  rw    <= rx_byte[0];
                end else begin
                  state <= ST_IGNORE;
                end
              end else begin
                bitcnt <= bitcnt + 4'd1;
              end
            end
          end

          ST_ADDR_ACK: begin
            if (scl_fall) begin
              if (!addr_ack_on) begin
                sda_oe      <= 1'b1;
                addr_ack_on <= 1'b1;
              end else begin
                addr_ack_on <= 1'b0;
                if (rw) begin
                  tx_sh  <= {tx_cur[6:0], 1'b0};
                  sda_oe <= ~tx_cur[7];
                  bitcnt <= 4'd1;
                  state  <= ST_TX;
                end else begin
                  sda_oe <= 1'b0;
                  bitcnt <= '0;
                  state  <= ST_RX_PTR;
                end
              end
            end
          end

          ST_RX_PTR, ST_RX_DATA: begin
            // The master's 9th (ACK) clock rise is ignored while ack_ph != 0.
            if (scl_rise && ack_ph == 2'd0) begin
              shreg <= rx_byte[6:0];
              if (bitcnt == 4'd7) begin
                bitcnt <= '0;
                ack_ph <= 2'd1;
                if (state == ST_RX_PTR) begin
                  ptr <= rx_byte[REG_AW-1:0];
                end else begin
                  regs[ptr]      <= rx_byte;
                  host.wr_strobe <= 1'b1;
                  host.wr_idx    <= ptr;
                  ptr            <= ptr + 1'b1;
                end
              end else begin
                bitcnt <= bitcnt + 4'd1;
              end
            end else if (scl_fall && ack_ph == 2'd1) begin
              sda_oe <= 1'b1;
              ack_ph <= 2'd2;
            end else if (scl_fall && ack_ph == 2'd2) begin
              sda_oe <= 1'b0;
              ack_ph <= 2'd0;
              state  <= ST_RX_DATA;
            end
          end

          ST_TX: begin
            if (scl_fall) begin
              if (bitcnt == 4'd8) begin
                sda_oe <= 1'b0;
                state  <= ST_TX_ACK;
              end else begin
                sda_oe <= ~tx_sh[7];
                tx_sh  <= {tx_sh[6:0], 1'b0};
                bitcnt <= bitcnt + 4'd1;
              end
            end
          end

          ST_TX_ACK: begin
            if (scl_rise) begin
              nack <= sda_f;
              ptr  <= ptr + 1'b1;
            end else if (scl_fall) begin
              if (!nack) begin
                tx_sh  <= {tx_cur[6:0], 1'b0};
                sda_oe <= ~tx_cur[7];
                bitcnt <= 4'd1;
                state  <= ST_TX;
              end else begin
                sda_oe <= 1'b0;
                state  <= ST_IGNORE;
              end
            end
          end

          default: begin
            sda_oe <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target_regfile.sv
module tb_i2c_target_regfile;

  localparam int H = 12;            // clk cycles per SCL half-period
  localparam logic [6:0] TADDR = 7'h42;

  typedef logic [7:0] bq_t [$];

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic m_scl = 1'b1;
  logic m_sda = 1'b1;
  logic glitch = 1'b0;
  logic glitch_en = 1'b0;
  logic scl_pin, sda_bus;
  logic sda_oe, busy;
  logic [6:0] address = TADDR;
  logic oe_seen = 1'b0;

  always #5 clk = ~clk;

  assign scl_pin = m_scl ^ glitch;
  assign sda_bus = m_sda & ~sda_oe;

  i2c_target_regfile_if #(.REG_AW(4)) hif ();

  i2c_target_regfile #(.REG_AW(4), .FILTER_LEN(3)) dut (
    .clk     (clk),
    .reset   (reset),
    .scl_in  (scl_pin),
    .sda_in  (sda_bus),
    .sda_oe  (sda_oe),
    .address (address),
    .busy    (busy),
    .host    (hif)
  );

  // Reference model: register contents and pointer.
  logic [7:0] mdl [16];
  logic [3:0] mptr;
  int         exp_wr [$];
  logic [7:0] exp_rd [$];
  logic [7:0] got_rd [$];

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Scoreboard monitors.
  always @(negedge clk) begin
    if (hif.wr_strobe) begin
      if (exp_wr.size() == 0) begin
        n_total++;
        $display("FAIL wr_unexpected: got idx 0x%0h expected no write", hif.wr_idx);
      end else begin
        check("wr_idx", int'(hif.wr_idx), exp_wr.pop_front());
      end
    end
    if (got_rd.size() > 0) begin
      logic [7:0] a;
      a = got_rd.pop_front();
      if (exp_rd.size() == 0) begin
        n_total++;
        $display("FAIL rd_unexpected: got 0x%0h expected nothing", a);
      end else begin
        check("rd_data", int'(a), int'(exp_rd.pop_front()));
      end
    end
    if (sda_oe) oe_seen <= 1'b1;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- bus master primitives (SCL low on entry/exit except start from idle)
  task automatic wbit(input logic b);
    tick(3);
    m_sda = b;
    if (glitch_en) begin tick(3); glitch = 1'b1; tick(1); glitch = 1'b0; tick(H-7); end
    else tick(H-3);
    m_scl = 1'b1;
    if (glitch_en) begin tick(H/2); glitch = 1'b1; tick(1); glitch = 1'b0; tick(H/2-1); end
    else tick(H);
    m_scl = 1'b0;
  endtask

  task automatic rbit(output logic b);
    tick(3);
    m_sda = 1'b1;
    tick(H-3);
    m_scl = 1'b1;
    tick(H/2);
    b = sda_bus;
    tick(H/2);
    m_scl = 1'b0;
  endtask

  task automatic bus_start();
    tick(3);
    m_sda = 1'b1;
    tick(H-3);
    m_scl = 1'b1;
    tick(H);
    m_sda = 1'b0;
    tick(H);
    m_scl = 1'b0;
  endtask

  task automatic bus_stop();
    tick(3);
    m_sda = 1'b0;
    tick(H-3);
    m_scl = 1'b1;
    tick(H);
    m_sda = 1'b1;
    tick(H);
  endtask

  task automatic wbyte(input logic [7:0] d, output logic ackbit);
    for (int i = 7; i >= 0; i--) wbit(d[i]);
    rbit(ackbit);
  endtask

  task automatic rbyte(input logic mack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      rbit(b);
      d[i] = b;
    end
    wbit(mack);
  endtask

  task automatic host_wr(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    hif.host_we    = 1'b1;
    hif.host_addr  = a;
    hif.host_wdata = d;
    tick(1);
    hif.host_we = 1'b0;
    mdl[a] = d;
  endtask

  // ---------------- transactions (model updated from the protocol rules)
  task automatic do_write(input logic [7:0] pb, input bq_t data, input bit do_stop);
    logic a;
    bus_start();
    wbyte({TADDR, 1'b0}, a);
    check("wr_addr_ack", int'(a), 0);
    check("busy_on_match", int'(busy), 1);
    wbyte(pb, a);
    check("ptr_ack", int'(a), 0);
    mptr = pb[3:0];
    foreach (data[k]) begin
      exp_wr.push_back(int'(mptr));
      mdl[mptr] = data[k];
      mptr = mptr + 4'd1;
      wbyte(data[k], a);
      check("data_ack", int'(a), 0);
    end
    if (do_stop) begin
      bus_stop();
      tick(8);
      check("busy_after_stop", int'(busy), 0);
    end
  endtask

  task automatic do_read(input int n);
    logic a;
    logic [7:0] d;
    bus_start();
    wbyte({TADDR, 1'b1}, a);
    check("rd_addr_ack", int'(a), 0);
    for (int k = 0; k < n; k++) begin
      exp_rd.push_back(mdl[mptr]);
      mptr = mptr + 4'd1;
      rbyte((k == n - 1), d);
      got_rd.push_back(d);
    end
    tick(8);
    check("sda_released_after_nack", int'(sda_oe), 0);
    bus_stop();
    tick(8);
    check("busy_after_rd_stop", int'(busy), 0);
  endtask

  task automatic sweep(input string nm);
    tick(4);
    for (int i = 0; i < 16; i++) begin
      hif.host_addr = 4'(i);
      tick(1);
      check(nm, int'(hif.host_rdata), int'(mdl[i]));
    end
  endtask

  initial begin
    logic a, b;
    bq_t q;
    hif.host_we = 1'b0;
    hif.host_addr = '0;
    hif.host_wdata = '0;
    for (int i = 0; i < 16; i++) mdl[i] = 8'h00;
    mptr = '0;

    // Reset state
    tick(4);
    reset = 1'b0;
    tick(1);
    check("rst_sda_oe", int'(sda_oe), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_wr_strobe", int'(hif.wr_strobe), 0);
    check("rst_wr_idx", int'(hif.wr_idx), 0);
    hif.host_addr = 4'd5;
    tick(1);
    check("rst_reg5", int'(hif.host_rdata), 0);

    // 1: write two bytes at pointer 5
    q = {8'hAA, 8'hBB};
    do_write(8'h05, q, 1'b1);

    // 2: host write, pointer set, repeated START, read 2 bytes
    host_wr(4'd3, 8'h5C);
    q = {};
    do_write(8'h03, q, 1'b0);
    do_read(2);
    do_read(1);                       // pointer left at 5

    // 3: foreign address ignored
    tick(4);
    oe_seen = 1'b0;
    bus_start();
    wbyte(8'h90, a);
    check("bad_addr_nack", int'(a), 1);
    check("bad_addr_busy", int'(busy), 0);
    wbyte(8'h01, a);
    check("ignored_byte1", int'(a), 1);
    wbyte(8'h77, a);
    check("ignored_byte2", int'(a), 1);
    bus_stop();
    tick(4);
    check("bad_addr_oe_seen", int'(oe_seen), 0);

    // 4: pointer wrap and upper pointer bits ignored
    q = {8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))};
    do_write(8'h0F, q, 1'b1);
    q = {};
    do_write(8'hF3, q, 1'b1);
    do_read(1);

    // 5: SCL glitches during the data phase
    glitch_en = 1'b1;
    q = {8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))};
    do_write(8'h08, q, 1'b1);
    glitch_en = 1'b0;

    // Randomised mix
    repeat (6) begin
      if ($urandom_range(0, 1) == 1) begin
        q = {};
        repeat ($urandom_range(1, 3)) q.push_back(8'($urandom_range(0, 255)));
        do_write(8'($urandom_range(0, 255)), q, 1'b1);
      end else begin
        host_wr(4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
        do_read($urandom_range(1, 3));
      end
    end

    sweep("reg_sweep_pre_reset");

    // 6: reset while the target is pulling SDA during a read
    host_wr(4'd9, 8'h21);
    q = {};
    do_write(8'h09, q, 1'b0);
    bus_start();
    wbyte({TADDR, 1'b1}, a);
    check("tx_addr_ack", int'(a), 0);
    rbit(b);
    check("tx_msb", int'(b), 0);
    tick(8);
    check("tx_driving_low", int'(sda_oe), 1);
    reset = 1'b1;
    tick(1);
    check("midrst_sda_oe", int'(sda_oe), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_wr_strobe", int'(hif.wr_strobe), 0);
    check("midrst_wr_idx", int'(hif.wr_idx), 0);
    reset = 1'b0;
    for (int i = 0; i < 16; i++) mdl[i] = 8'h00;
    mptr = '0;
    m_sda = 1'b1;
    m_scl = 1'b1;
    tick(2 * H);
    sweep("reg_sweep_after_reset");
    q = {8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))};
    do_write(8'h02, q, 1'b1);
    q = {};
    do_write(8'h02, q, 1'b0);
    do_read(2);

    tick(20);
    check("wr_queue_drained", exp_wr.size(), 0);
    check("rd_queue_drained", exp_rd.size(), 0);
    sweep("reg_sweep_final");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
